// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder/subtractor cell resolves WIDTH-bit operands LSB-first.
// Optional signed-overflow output is built when SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] res_sr_r;
    logic [WIDTH-1:0] res_sr_nxt_s;
    logic [WIDTH-1:0] result_r;
    logic [CW-1:0]    cnt_r;
    logic             sub_r;
    logic             cy_r;
    logic             c_out_r;
    logic             sum_s;
    logic             cy_nxt_s;
    logic             last_s;

    function automatic logic cell_sum(input logic ai, input logic bi, input logic ci);
        return ai ^ bi ^ ci;
    endfunction

    // Carry for add, borrow for subtract.
    function automatic logic cell_cy(input logic ai, input logic bi, input logic ci,
                                     input logic sub_i);
        logic cy_v;
        if (sub_i) begin
            cy_v = (~ai & bi) | (~(ai ^ bi) & ci);
        end else begin
            cy_v = (ai & bi) | ((ai ^ bi) & ci);
        end
        return cy_v;
    endfunction

    // Bit cell evaluation and next-state decode.
    always_comb begin
        state_nxt_s  = state_r;
        sum_s        = cell_sum(a_sr_r[0], b_sr_r[0], cy_r);
        cy_nxt_s     = cell_cy(a_sr_r[0], b_sr_r[0], cy_r, sub_r);
        last_s       = (cnt_r == CNT_LAST);
        res_sr_nxt_s = {sum_s, res_sr_r[WIDTH-1:1]};
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand/result shift registers, carry flop, bit counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r   <= {WIDTH{1'b0}};
            b_sr_r   <= {WIDTH{1'b0}};
            res_sr_r <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            sub_r    <= 1'b0;
            cy_r     <= 1'b0;
            c_out_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_valid) begin
                        a_sr_r   <= a;
                        b_sr_r   <= b;
                        sub_r    <= sub;
                        cy_r     <= c_in;
                        cnt_r    <= {CW{1'b0}};
                        res_sr_r <= {WIDTH{1'b0}};
                    end
                end
                RUN: begin
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    res_sr_r <= res_sr_nxt_s;
                    cy_r     <= cy_nxt_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        result_r <= res_sr_nxt_s;
                        c_out_r  <= cy_nxt_s;
                    end
                end
                DONE: begin
                    cnt_r <= cnt_r;
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic cy_msb_r;
    logic ovf_r;

    // Carry into the MSB is captured one step early so ovf can be registered on DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cy_msb_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (state_r == RUN) begin
                if (cnt_r == CNT_MSB_IN) begin
                    cy_msb_r <= cy_nxt_s;
                end
                if (last_s) begin
                    ovf_r <= cy_msb_r ^ cy_nxt_s;
                end
            end
        end
    end

    assign ovf = ovf_r;
`endif

    assign start_ready = (state_r == IDLE);
    assign res_valid   = (state_r == DONE);
    assign result      = result_r;
    assign c_out       = c_out_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub (WIDTH=8): directed scenarios plus random ops vs an arithmetic model.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         c_in;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         c_out;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_cyc;
    int prev_done_cyc;

    serial_addsub #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .sub         (sub),
        .c_in        (c_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .c_out       (c_out)
`ifdef SERIAL_ADDSUB_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: plain integer add/subtract and signed range test.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                         input logic mcin, output logic [W-1:0] r, output logic co,
                         output logic ov);
        int t;
        int st;
        int sa;
        int sb;
        sa = $signed(ma);
        sb = $signed(mb);
        if (!msub) begin
            t  = int'(ma) + int'(mb) + int'(mcin);
            st = sa + sb + int'(mcin);
            co = (t > 255);
        end else begin
            t  = int'(ma) - int'(mb) - int'(mcin);
            st = sa - sb - int'(mcin);
            co = (t < 0);
        end
        r  = W'(t);
        ov = (st > 127) || (st < -128);
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                         input logic icin);
        chk("start_ready_before_issue", 32'(start_ready), 32'd1);
        start_valid = 1'b1;
        a = ia;
        b = ib;
        sub = isub;
        c_in = icin;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub = 1'($urandom);
        c_in = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!res_valid && lat < 100);
        done_cyc = cyc;
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] er, input logic eco,
                                 input logic eov);
        chk({tag, "_result"}, 32'(result), 32'(er));
        chk({tag, "_c_out"}, 32'(c_out), 32'(eco));
`ifdef SERIAL_ADDSUB_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eov));
`else
        if (eov === 1'bx) $display("unreachable");
`endif
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic isub, input logic icin);
        logic [W-1:0] er;
        logic         eco;
        logic         eov;
        int           lat;
        model(ia, ib, isub, icin, er, eco, eov);
        res_ready = 1'b1;
        issue(ia, ib, isub, icin);
        wait_result(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        check_outputs(tag, er, eco, eov);
        @(posedge clk);
        #1;
        chk({tag, "_res_valid_after"}, 32'(res_valid), 32'd0);
        chk({tag, "_start_ready_after"}, 32'(start_ready), 32'd1);
    endtask

    initial begin
        logic [W-1:0] er;
        logic         eco;
        logic         eov;
        int           lat;

        rst_n = 1'b0;
        start_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        c_in = 1'b0;
        res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_start_ready", 32'(start_ready), 32'd1);
        chk("reset_res_valid", 32'(res_valid), 32'd0);
        check_outputs("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Directed arithmetic cases.
        run_op("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        run_op("add_00_00_cin", 8'h00, 8'h00, 1'b0, 1'b1);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0);
        run_op("sub_00_00_bin", 8'h00, 8'h00, 1'b1, 1'b1);
        run_op("add_7f_7f_cin", 8'h7F, 8'h7F, 1'b0, 1'b1);

        // Back-to-back issue interval.
        run_op("b2b_first", 8'h11, 8'h22, 1'b0, 1'b0);
        prev_done_cyc = done_cyc;
        run_op("b2b_second", 8'h33, 8'h44, 1'b1, 1'b1);
        chk("b2b_interval", 32'(done_cyc - prev_done_cyc), 32'(W + 2));

        // Backpressure in DONE with ignored start pulses.
        model(8'h12, 8'h34, 1'b0, 1'b0, er, eco, eov);
        res_ready = 1'b0;
        issue(8'h12, 8'h34, 1'b0, 1'b0);
        wait_result(lat);
        chk("hold_latency", 32'(lat), 32'(W));
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_start_ready", 32'(start_ready), 32'd0);
            check_outputs("hold", er, eco, eov);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_res_valid", 32'(res_valid), 32'd0);
        chk("release_start_ready", 32'(start_ready), 32'd1);
        check_outputs("idle_hold", er, eco, eov);
        @(posedge clk);
        #1;
        chk("pulses_ignored_start_ready", 32'(start_ready), 32'd1);

        // Asynchronous reset during the third RUN cycle.
        issue(8'hAA, 8'h55, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_start_ready", 32'(start_ready), 32'd1);
        chk("async_rst_res_valid", 32'(res_valid), 32'd0);
        check_outputs("async_rst", 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_op("post_rst_add", 8'h01, 8'h02, 1'b0, 1'b0);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial adder/subtractor. It accepts two WIDTH-bit operands through a valid/ready handshake and resolves them LSB-first, one bit per clock, through a single full-adder/full-subtractor cell and a carry/borrow flip-flop. The result, carry or borrow, and optional signed overflow are then presented through a second valid/ready handshake. It is the area-minimal sequential arithmetic unit of the arithmetic library, used wherever a parallel ripple adder/subtractor is too large.

## Interface
- WIDTH, default 8: operand and result width in bits; legal values are 2 to 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_valid  in  1  an operation request is present on a, b, sub, c_in.
- start_ready  out  1  the block can accept a request (high only in IDLE).
- a  in  WIDTH  minuend (subtract) or augend (add).
- b  in  WIDTH  subtrahend or addend.
- sub  in  1  0 = a + b + c_in; 1 = a − b − c_in.
- c_in  in  1  initial carry (add) or borrow (subtract).
- res_valid  out  1  result, c_out and ovf are valid.
- res_ready  in  1  the consumer accepts the result.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- c_out  out  1  final carry (add) or final borrow (subtract).
- ovf  out  1  signed overflow; present only when the macro is defined (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start_ready=1.
  - On start_valid: latch a, b, sub and c_in into shift registers; load cy ← c_in and cnt ← 0; go to RUN.
- RUN, per cycle, on the LSBs ai and bi of the operand shift registers:
  - Add: s = ai^bi^cy; cy ← (ai&bi) | ((ai^bi)&cy).
  - Subtract: s = ai^bi^cy; cy ← (~ai&bi) | (~(ai^bi)&cy).
  - Shift s into result_sr from the MSB side; shift both operands right; cnt ← cnt+1.
  - When cnt = WIDTH−1, the next state is DONE.
- Entering DONE:
  - result ← final result_sr.
  - c_out ← final cy.
  - ovf ← carry/borrow into the MSB XOR the final carry/borrow.
- DONE: res_valid=1. On res_ready, go to IDLE.
- Output hold: result, c_out and ovf are registered and hold their value until the next entry to DONE, including while in IDLE.
- Request gating: start_valid is ignored outside IDLE. Operand inputs are sampled only on the accepting edge and may change freely afterwards.
- Width rule: cnt is clog2(WIDTH) bits wide. No width extension is done; the carry/borrow out is reported only through c_out.

## Timing
- Accept edge E0 is the edge with start_valid&start_ready. RUN occupies edges E1..E_WIDTH, and res_valid rises after E_WIDTH. Latency is therefore WIDTH cycles from acceptance to result.
- If res_ready is already high when res_valid rises, the result is consumed at the next edge. start_ready is then high on the following cycle, and that cycle can accept a new request.
- Minimum issue interval is WIDTH+2 cycles.
- No combinational path from any input to any output. start_ready and res_valid are decoded from state flops only.
- Reset, including mid-RUN or mid-DONE, immediately forces:
  - state=IDLE, start_ready=1, res_valid=0;
  - result=0, c_out=0, ovf=0;
  - all internal registers cleared.
  - An operation in flight is discarded, with no partial result.
- After rst_n deasserts, the first edge can accept a request.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined:
  - The ovf port and its flop exist.
  - An extra flop captures cy before the MSB step.
  - ovf = cy_msb_in ^ cy_final for both add and subtract.
- Not defined:
  - The ovf port is absent and no overflow logic is instantiated.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use WIDTH=8.
1. Add 0x3C + 0x5A, c_in=0, res_ready=1. Required: res_valid exactly 8 cycles after accept; result=0x96, c_out=0, ovf=1.
2. Add 0xFF + 0x01, c_in=0. Required: result=0x00, c_out=1, ovf=0. Add 0x00 + 0x00 with c_in=1. Required: result=0x01, c_out=0.
3. Subtract 0x10 − 0x20, bIn=0. Required: result=0xF0, c_out=1 (borrow), ovf=0. Subtract 0x80 − 0x01. Required: result=0x7F, c_out=0, ovf=1.
4. Hold res_ready=0 for 5 cycles in DONE while pulsing start_valid with new operands. Required:
   - result and res_valid stay stable, start_ready stays 0, and the pulses are ignored.
   - Raising res_ready returns the block to IDLE next cycle.
   - Back-to-back operations complete WIDTH+2 cycles apart.
5. Assert rst_n=0 on the 3rd RUN cycle of 0xAA + 0x55. Required: all outputs go to reset values without waiting for clk. After release, 0x01 + 0x02 gives result=0x03, c_out=0.
6. Build without SERIAL_ADDSUB_OVF_EN and rerun scenarios 1–3. Required: identical result, c_out and latency; no ovf port.
